video_crop: RTL and testbench

Downstream stage of the colour-mix output in the TurboGrafx16 video path. It measures the active raster (pixels per line, lines per frame) from the blank signals and locks once two consecutive frames agree. When enabled and locked, it removes a programmable overscan border on all four sides by forcing RGB to zero and extending HBlank/VBlank. Outputs feed the framework video output with one pixel of latency.

---
 rtl/video_crop.sv | 217 +++++++++++++++++++++
 tb/tb_video_crop.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/video_crop.sv
// video_crop: measures the active raster from the blank signals and locks
// once two consecutive frames agree. While locked and enabled it blanks a
// programmable border on all four sides. One ce_pix of latency on all outputs.
module video_crop (
    input  logic       clk_vid,
    input  logic       reset_n,
    input  logic       ce_pix,
    input  logic       crop_en,
    input  logic [5:0] crop_h,
    input  logic [4:0] crop_v,
    input  logic [7:0] R_in,
    input  logic [7:0] G_in,
    input  logic [7:0] B_in,
    input  logic       HSync_in,
    input  logic       VSync_in,
    input  logic       HBlank_in,
    input  logic       VBlank_in,
    output logic [7:0] R_out,
    output logic [7:0] G_out,
    output logic [7:0] B_out,
    output logic       HSync_out,
    output logic       VSync_out,
    output logic       HBlank_out,
    output logic       VBlank_out,
    output logic [9:0] active_w,
    output logic [8:0] active_h,
    output logic       locked
);

    typedef enum logic [1:0] {
        S_UNLOCKED  = 2'd0,
        S_MEASURING = 2'd1,
        S_LOCKED    = 2'd2
    } state_t;

    // Raster measurement state
    logic       hb_q, vb_q;
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic [9:0] frame_w_q;
    logic       frame_bad_q;
    logic       first_line_q;

    // Geometry FSM state
    state_t     state_q, state_d;
    logic [9:0] cand_w_q, cand_w_d;
    logic [8:0] cand_h_q, cand_h_d;
    logic [9:0] active_w_q, active_w_d;
    logic [8:0] active_h_q, active_h_d;

    // Output registers
    logic [7:0] r_q, g_q, b_q;
    logic       hs_q, vs_q, hblank_q, vblank_q;

    // Edge and frame-summary terms
    logic       hb_rise, vb_rise, line_end, frame_end;
    logic [9:0] x_inc, frame_w_eff;
    logic [8:0] y_inc, frame_h_eff;
    logic       width_mismatch, frame_valid;

    // Crop terms
    logic        crop_gate, hz_hit, vt_hit, crop_hz, crop_vt, crop_any;
    logic [10:0] x_sum;
    logic [9:0]  y_sum;

    assign hb_rise   = ~hb_q & HBlank_in;
    assign vb_rise   = ~vb_q & VBlank_in;
    // A line that ends on the same pixel as VBlank rises still counts, so the
    // last line is included in the frame height.
    assign line_end  = ce_pix & hb_rise & (~VBlank_in | vb_rise);
    assign frame_end = ce_pix & vb_rise;

    assign x_inc = (x_q == 10'h3FF) ? x_q : x_q + 10'd1;
    assign y_inc = (y_q == 9'h1FF)  ? y_q : y_q + 9'd1;

    // Frame summary as it will be once this pixel's line-end update lands
    assign width_mismatch = ~first_line_q & (x_q != frame_w_q);
    assign frame_w_eff    = (line_end & first_line_q) ? x_q : frame_w_q;
    assign frame_h_eff    = line_end ? y_inc : y_q;
    assign frame_valid    = ~(frame_bad_q | (line_end & width_mismatch))
                            & (frame_h_eff != 9'd0);

    // Pixel/line counters and per-frame width consistency tracking
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            hb_q         <= 1'b1;
            vb_q         <= 1'b1;
            x_q          <= 10'd0;
            y_q          <= 9'd0;
            frame_w_q    <= 10'd0;
            frame_bad_q  <= 1'b0;
            first_line_q <= 1'b1;
        end else if (ce_pix) begin
            hb_q <= HBlank_in;
            vb_q <= VBlank_in;
            x_q  <= HBlank_in ? 10'd0 : x_inc;
            if (VBlank_in)
                y_q <= 9'd0;
            else if (line_end)
                y_q <= y_inc;
            if (frame_end) begin
                frame_bad_q  <= 1'b0;
                first_line_q <= 1'b1;
            end else if (line_end) begin
                if (first_line_q) begin
                    frame_w_q    <= x_q;
                    first_line_q <= 1'b0;
                end else if (width_mismatch) begin
                    frame_bad_q  <= 1'b1;
                end
            end
        end
    end

    // Geometry FSM: state and geometry registers
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_UNLOCKED;
            cand_w_q   <= 10'd0;
            cand_h_q   <= 9'd0;
            active_w_q <= 10'd0;
            active_h_q <= 9'd0;
        end else begin
            state_q    <= state_d;
            cand_w_q   <= cand_w_d;
            cand_h_q   <= cand_h_d;
            active_w_q <= active_w_d;
            active_h_q <= active_h_d;
        end
    end

    // Geometry FSM: next state, evaluated only at frame end
    always_comb begin
        state_d    = state_q;
        cand_w_d   = cand_w_q;
        cand_h_d   = cand_h_q;
        active_w_d = active_w_q;
        active_h_d = active_h_q;
        if (frame_end) begin
            case (state_q)
                S_UNLOCKED: begin
                    if (frame_valid) begin
                        state_d  = S_MEASURING;
                        cand_w_d = frame_w_eff;
                        cand_h_d = frame_h_eff;
                    end
                end
                S_MEASURING: begin
                    if (!frame_valid) begin
                        state_d = S_UNLOCKED;
                    end else if (frame_w_eff == cand_w_q && frame_h_eff == cand_h_q) begin
                        state_d    = S_LOCKED;
                        active_w_d = cand_w_q;
                        active_h_d = cand_h_q;
                    end else begin
                        cand_w_d = frame_w_eff;
                        cand_h_d = frame_h_eff;
                    end
                end
                S_LOCKED: begin
                    if (!frame_valid || frame_w_eff != active_w_q || frame_h_eff != active_h_q)
                        state_d = S_UNLOCKED;
                end
                default: state_d = S_UNLOCKED;
            endcase
        end
    end

    // Geometry FSM: outputs
    always_comb begin
        locked   = (state_q == S_LOCKED);
        active_w = active_w_q;
        active_h = active_h_q;
    end

    // Border test for the current pixel; oversized crops simply blank everything
    always_comb begin
        crop_gate = crop_en & locked & ~HBlank_in & ~VBlank_in;
        x_sum     = {1'b0, x_q} + {5'd0, crop_h};
        y_sum     = {1'b0, y_q} + {5'd0, crop_v};
        hz_hit    = (x_q < {4'd0, crop_h}) | (x_sum >= {1'b0, active_w_q});
        vt_hit    = (y_q < {4'd0, crop_v}) | (y_sum >= {1'b0, active_h_q});
        crop_hz   = crop_gate & hz_hit;
        crop_vt   = crop_gate & vt_hit;
        crop_any  = crop_hz | crop_vt;
    end

    // Output pixel register
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r_q      <= 8'd0;
            g_q      <= 8'd0;
            b_q      <= 8'd0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            hblank_q <= 1'b1;
            vblank_q <= 1'b1;
        end else if (ce_pix) begin
            r_q      <= crop_any ? 8'd0 : R_in;
            g_q      <= crop_any ? 8'd0 : G_in;
            b_q      <= crop_any ? 8'd0 : B_in;
            hs_q     <= HSync_in;
            vs_q     <= VSync_in;
            hblank_q <= HBlank_in | crop_hz;
            vblank_q <= VBlank_in | crop_vt;
        end
    end

    assign R_out      = r_q;
    assign G_out      = g_q;
    assign B_out      = b_q;
    assign HSync_out  = hs_q;
    assign VSync_out  = vs_q;
    assign HBlank_out = hblank_q;
    assign VBlank_out = vblank_q;

endmodule

// File: tb/tb_video_crop.sv
// Directed bench for video_crop on a scaled-down raster (40/56 x 16 active,
// 8-pixel hblank, 3 vblank lines) with an expected-pixel queue.
module tb_video_crop;

    logic       clk_vid = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce_pix = 1'b0;
    logic       crop_en = 1'b0;
    logic [5:0] crop_h = 6'd0;
    logic [4:0] crop_v = 5'd0;
    logic [7:0] R_in = 8'd0, G_in = 8'd0, B_in = 8'd0;
    logic       HSync_in = 1'b0, VSync_in = 1'b0, HBlank_in = 1'b1, VBlank_in = 1'b1;
    logic [7:0] R_out, G_out, B_out;
    logic       HSync_out, VSync_out, HBlank_out, VBlank_out;
    logic [9:0] active_w;
    logic [8:0] active_h;
    logic       locked;

    video_crop dut (
        .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix),
        .crop_en(crop_en), .crop_h(crop_h), .crop_v(crop_v),
        .R_in(R_in), .G_in(G_in), .B_in(B_in),
        .HSync_in(HSync_in), .VSync_in(VSync_in),
        .HBlank_in(HBlank_in), .VBlank_in(VBlank_in),
        .R_out(R_out), .G_out(G_out), .B_out(B_out),
        .HSync_out(HSync_out), .VSync_out(VSync_out),
        .HBlank_out(HBlank_out), .VBlank_out(VBlank_out),
        .active_w(active_w), .active_h(active_h), .locked(locked)
    );

    always #5 clk_vid = ~clk_vid;

    localparam int HBL = 8;
    localparam int VBL = 3;

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hs, vs, hb, vb;
    } pix_t;

    pix_t exp_q[$];
    int   total = 0;
    int   fails = 0;
    bit   exp_locked = 1'b0;
    int   exp_aw = 0;
    int   exp_ah = 0;
    bit   gaps = 1'b0;

    function automatic logic [31:0] outv();
        return {4'h0, R_out, G_out, B_out, HSync_out, VSync_out, HBlank_out, VBlank_out};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic geom(string tag, bit l, int w, int h);
        chk({tag, "_locked"}, 32'(locked), 32'(l));
        chk({tag, "_active_w"}, 32'(active_w), 32'(w));
        chk({tag, "_active_h"}, 32'(active_h), 32'(h));
        $display("frame %s: locked=%0d active_w=%0d active_h=%0d", tag, locked, active_w, active_h);
    endtask

    // Drive one pixel, queue its expected output, compare after the ce edge
    task automatic px(int x, int y, logic hb, logic vb, logic hs, logic vs);
        pix_t e;
        logic [7:0] r, g, b;
        bit act, hz, vt;
        r   = 8'(x * 3 + 1);
        g   = 8'(y * 5 + 7);
        b   = 8'($urandom_range(0, 255));
        act = crop_en && exp_locked && !hb && !vb;
        hz  = act && (x < int'(crop_h) || x + int'(crop_h) >= exp_aw);
        vt  = act && (y < int'(crop_v) || y + int'(crop_v) >= exp_ah);
        e.r  = (hz || vt) ? 8'h00 : r;
        e.g  = (hz || vt) ? 8'h00 : g;
        e.b  = (hz || vt) ? 8'h00 : b;
        e.hs = hs;
        e.vs = vs;
        e.hb = hb | hz;
        e.vb = vb | vt;
        exp_q.push_back(e);
        R_in = r; G_in = g; B_in = b;
        HSync_in = hs; VSync_in = vs; HBlank_in = hb; VBlank_in = vb;
        ce_pix = 1'b1;
        @(posedge clk_vid); #1;
        e = exp_q.pop_front();
        chk("pixel", outv(), 32'(e));
        if (gaps) begin
            ce_pix = 1'b0;
            repeat (3) begin
                @(posedge clk_vid); #1;
                chk("gap_hold", outv(), 32'(e));
            end
        end
    endtask

    // Asynchronous reset between clock edges; outputs must drop at once
    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_out", outv(), 32'h3);
        chk("rst_async_locked", 32'(locked), 32'd0);
        chk("rst_async_aw", 32'(active_w), 32'd0);
        chk("rst_async_ah", 32'(active_h), 32'd0);
        @(posedge clk_vid); #1;
        chk("rst_hold_out", outv(), 32'h3);
        reset_n    = 1'b1;
        exp_locked = 1'b0;
        exp_aw     = 0;
        exp_ah     = 0;
        $display("mid-frame reset applied and released");
    endtask

    task automatic frame(int w, int h, int bad_line, int rst_line, int rst_px);
        for (int l = 0; l < h + VBL; l++) begin
            int  lw;
            logic vb;
            vb = (l >= h);
            lw = (l == bad_line) ? w - 1 : w;
            for (int x = 0; x < lw + HBL; x++) begin
                logic hb, hs, vs;
                hb = (x >= lw);
                hs = (x >= lw + 2) && (x < lw + 5);
                vs = (l == h + 1);
                if (l == rst_line && x == rst_px)
                    do_reset();
                px(x, l, hb, vb, hs, vs);
            end
        end
    endtask

    initial begin
        // Reset held with live, non-blank inputs: outputs stay at reset values
        reset_n = 1'b0; ce_pix = 1'b1;
        R_in = 8'hAA; G_in = 8'h55; B_in = 8'h11;
        HSync_in = 1'b1; VSync_in = 1'b1; HBlank_in = 1'b0; VBlank_in = 1'b0;
        repeat (3) @(posedge clk_vid);
        #1;
        chk("reset_out", outv(), 32'h3);
        geom("reset", 1'b0, 0, 0);
        HBlank_in = 1'b1; VBlank_in = 1'b1;
        reset_n = 1'b1;

        // Lock on a 40x16 raster, crop disabled
        frame(40, 16, -1, -1, -1); geom("f1_measure", 1'b0, 0, 0);
        frame(40, 16, -1, -1, -1); geom("f2_lock", 1'b1, 40, 16);
        exp_locked = 1'b1; exp_aw = 40; exp_ah = 16;

        // Cropped frame
        crop_en = 1'b1; crop_h = 6'd4; crop_v = 5'd3;
        frame(40, 16, -1, -1, -1); geom("f3_crop", 1'b1, 40, 16);

        // Resize to 56 wide: first frame still cropped with old geometry
        frame(56, 16, -1, -1, -1); geom("f4_resize", 1'b0, 40, 16);
        exp_locked = 1'b0;
        frame(56, 16, -1, -1, -1); geom("f5_measure", 1'b0, 40, 16);
        frame(56, 16, -1, -1, -1); geom("f6_relock", 1'b1, 56, 16);
        exp_locked = 1'b1; exp_aw = 56;

        // One short line makes the frame invalid
        frame(56, 16, 5, -1, -1); geom("f7_badline", 1'b0, 56, 16);
        exp_locked = 1'b0;
        frame(56, 16, -1, -1, -1); geom("f8_measure", 1'b0, 56, 16);
        frame(56, 16, -1, -1, -1); geom("f9_relock", 1'b1, 56, 16);
        exp_locked = 1'b1;

        // ce_pix gaps of 3 clocks between pixels
        gaps = 1'b1;
        frame(56, 16, -1, -1, -1); geom("f10_gaps", 1'b1, 56, 16);
        gaps = 1'b0;

        // Oversized horizontal crop blanks every active pixel
        crop_h = 6'd30;
        frame(56, 16, -1, -1, -1); geom("f11_oversize", 1'b1, 56, 16);
        crop_h = 6'd4;

        // Reset mid-line while locked; partial frame plus two full frames to relock
        frame(56, 16, -1, 8, 20); geom("f12_partial", 1'b0, 0, 0);
        frame(56, 16, -1, -1, -1); geom("f13_measure", 1'b0, 0, 0);
        frame(56, 16, -1, -1, -1); geom("f14_relock", 1'b1, 56, 16);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
